// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshakes on
// operands and results. Single-cycle logic/arith/shift/compare ops;
// iterative shift-add multiply (signed and unsigned, HI/LO result).
// Optional iterative restoring divide, built only when ALU_MC_DIV_EN is
// defined. Without it, DIV/DIVU are treated as illegal ops.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// BUSY  | one mul/div step per cycle, WIDTH steps
// DONE  | result registers valid, held until out_ready
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1110;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // mul high partial / div remainder
  logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   mb_q, mb_d;       // multiplicand or divisor magnitude
  logic               neg_q, neg_d;     // negate product / quotient at the end
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   diff, sc_res, mag_a, mag_b, acc_step, lo_step;
  logic               sc_err, slt, sgn_op, is_long;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

`ifdef ALU_MC_DIV_EN
  logic               div_q, div_d;
  logic               nega_q, nega_d;   // remainder follows the sign of a
  logic [WIDTH-1:0]   a_q, a_d;         // original dividend, returned on divide-by-zero
  logic [WIDTH:0]     div_sh, div_dif;
`endif

  // Single-cycle ops and operand magnitudes for the iterative units
  always_comb begin
    diff   = a - b;
    slt    = diff[WIDTH-1] ^ ((a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]));
    sc_res = '0;
    sc_err = 1'b0;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD:  sc_res = a + b;
      OP_ANDN: sc_res = a & ~b;
      OP_ORN:  sc_res = a | ~b;
      OP_SUB:  sc_res = diff;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:  sc_res = a << b[SHW-1:0];
      OP_SRL:  sc_res = a >> b[SHW-1:0];
      OP_SRA:  sc_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: sc_err = 1'b1;
    endcase
    sgn_op = (op == OP_MUL) || (op == OP_DIV);
    mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
`ifdef ALU_MC_DIV_EN
    is_long = (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    is_long = (op == OP_MUL) || (op == OP_MULU);
`endif
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum  = lo_q[0] ? ({1'b0, acc_q} + {1'b0, mb_q}) : {1'b0, acc_q};
    acc_step = mul_sum[WIDTH:1];
    lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_sh  = {acc_q, lo_q[WIDTH-1]};
    div_dif = div_sh - {1'b0, mb_q};
    if (div_q) begin
      if (!div_dif[WIDTH]) begin
        acc_step = div_dif[WIDTH-1:0];
        lo_step  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_sh[WIDTH-1:0];
        lo_step  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // FSM next state, handshake outputs and datapath register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    mb_d      = mb_q;
    neg_d     = neg_q;
    res_d     = res_q;
    hi_d      = hi_q;
    err_d     = err_q;
    prod      = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ALU_MC_DIV_EN
    div_d  = div_q;
    nega_d = nega_q;
    a_d    = a_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_long) begin
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = mag_a;
            mb_d    = mag_b;
            neg_d   = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MC_DIV_EN
            div_d   = (op == OP_DIV) || (op == OP_DIVU);
            nega_d  = sgn_op & a[WIDTH-1];
            a_d     = a;
`endif
            state_d = S_BUSY;
          end else begin
            res_d   = sc_res;
            hi_d    = '0;
            err_d   = sc_err;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + SHW'(1);
        acc_d = acc_step;
        lo_d  = lo_step;
        if (cnt_q == CNT_LAST) begin
          prod    = {acc_step, lo_step};
          if (neg_q) prod = -prod;
          res_d   = prod[WIDTH-1:0];
          hi_d    = prod[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
`ifdef ALU_MC_DIV_EN
          if (div_q) begin
            if (mb_q == '0) begin
              res_d = '1;
              hi_d  = a_q;
              err_d = 1'b1;
            end else begin
              res_d = neg_q ? -lo_step : lo_step;
              hi_d  = nega_q ? -acc_step : acc_step;
            end
          end
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
      div_q   <= 1'b0;
      nega_q  <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
`ifdef ALU_MC_DIV_EN
      div_q   <= div_d;
      nega_q  <= nega_d;
      a_q     <= a_d;
`endif
    end
  end

  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = out_valid & (res_q == '0);
  assign err       = out_valid & err_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=32). Expected results are
// produced by a behavioural model when an op is driven and compared when
// out_valid appears. Build with ALU_MC_DIV_EN to exercise the divider.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sp;
    longint unsigned up;
    e.res = '0;
    e.hi  = '0;
    e.err = 1'b0;
    e.lat = 1;
    case (o)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2:  e.res = x + y;
      4'd4:  e.res = x & ~y;
      4'd5:  e.res = x | ~y;
      4'd6:  e.res = x - y;
      4'd7:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  e.res = x << y[4:0];
      4'd9:  e.res = x >> y[4:0];
      4'd10: e.res = $signed(x) >>> y[4:0];
      4'd14: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd3: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {e.hi, e.res} = sp;
        e.lat = 33;
      end
      4'd11: begin
        up = 64'(x);
        up = up * 64'(y);
        {e.hi, e.res} = up;
        e.lat = 33;
      end
`ifdef ALU_MC_DIV_EN
      4'd12, 4'd13: begin
        e.lat = 33;
        if (y == 32'd0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = x;
          e.err = 1'b1;
        end else if (o == 4'd12 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.res = 32'h8000_0000;
          e.hi  = 32'd0;
        end else if (o == 4'd12) begin
          e.res = $signed(x) / $signed(y);
          e.hi  = $signed(x) % $signed(y);
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one op, wait for its result, compare against the scoreboard,
  // then optionally hold out_ready low for 'hold' cycles.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    int n;
    int guard;
    int rdy_busy;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", in_ready, 1);
    out_ready = (hold == 0);
    a = x;
    b = y;
    op = o;
    in_valid = 1'b1;
    sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 0;
    rdy_busy = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) rdy_busy++;
    end while (!out_valid && n < 100);
    chk("out_valid", out_valid, 1);
    chk("sb_pending", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk($sformatf("latency op%0d", o), n, e.lat);
      chk($sformatf("busy_ready op%0d", o), rdy_busy, 0);
      chk($sformatf("result op%0d", o), result, e.res);
      chk($sformatf("result_hi op%0d", o), result_hi, e.hi);
      chk($sformatf("err op%0d", o), err, e.err);
      chk($sformatf("zero op%0d", o), zero, (e.res == 32'd0));
      chk("done_ready", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, e.res);
        chk("hold_zero", zero, (e.res == 32'd0));
        chk("hold_ready", in_ready, 0);
      end
      if (hold > 0) begin
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", in_ready, 1);
        chk("release_valid", out_valid, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ro;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    run_op(4'd2,  32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'd7,  32'h8000_0000, 32'd1, 0);
    run_op(4'd14, 32'h8000_0000, 32'd1, 0);
    run_op(4'd10, 32'hF000_0000, 32'd4, 0);
    run_op(4'd8,  32'h0000_00F1, 32'hFFFF_FFE4, 0);
    run_op(4'd9,  32'h8000_0000, 32'd31, 0);
    run_op(4'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(4'd1,  32'hF000_0000, 32'h0000_000F, 0);
    run_op(4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 0);
    run_op(4'd5,  32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op(4'd3,  32'hFFFF_FFFD, 32'd7, 0);
    run_op(4'd3,  32'h8000_0000, 32'h8000_0000, 0);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(4'd12, 32'd5, 32'd0, 0);
    run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd13, 32'd100, 32'd7, 0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'd0, 0);
    run_op(4'd15, 32'd1, 32'd2, 0);
    run_op(4'd6,  32'd10, 32'd10, 5);

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      run_op(ro, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom, 0);
    end

    // Reset in the middle of an unsigned multiply
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    op = 4'd11;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_result_hi", result_hi, 0);
    chk("mid_rst_zero", zero, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 32'd2, 32'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
